// File: rtl/srx_pkg.sv
// Shared types and sizing for the iterative right shifter.
package srx_pkg;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned SHAMT_W = 5;
   localparam int unsigned STEP    = 4;
   localparam int unsigned K_W     = $clog2(STEP) + 1;

   typedef enum logic [1:0] {
      SRX_IDLE,
      SRX_SHIFT,
      SRX_DONE
   } srx_state_e;

endpackage : srx_pkg

// File: rtl/srx_step.sv
// One iteration of the right shifter: shift by k (0..STEP), back-fill with fill.
module srx_step
   import srx_pkg::*;
(
   input  logic [DATA_W-1:0] word,
   input  logic [K_W-1:0]    k,
   input  logic              fill,
   output logic [DATA_W-1:0] shifted
);

   logic [DATA_W-1:0] ones;
   logic [DATA_W-1:0] top_mask;

   // Vacated top bits are selected by a shifted all-ones mask.
   always_comb begin
      ones     = '1;
      top_mask = ~(ones >> k);
      shifted  = (word >> k) | (fill ? top_mask : '0);
   end

endmodule : srx_step

// File: rtl/srx_iter_32bit.sv
// Multi-cycle SRL/SRA unit retiring up to STEP bit positions per cycle.
module srx_iter_32bit
   import srx_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   output logic               ready_o,
   input  logic [DATA_W-1:0]  a_i,
   input  logic [SHAMT_W-1:0] shift_i,
   input  logic               arith_i,
   output logic [DATA_W-1:0]  s_o,
   output logic               valid_o,
   input  logic               ack_i
);

   srx_state_e         state;
   logic [DATA_W-1:0]  work;
   logic [SHAMT_W-1:0] count;
   logic               fill;
   logic               valid_q;

   logic [K_W-1:0]     k_c;
   logic [DATA_W-1:0]  step_word;

   // Bits retired this cycle: the remaining count, capped at STEP.
   always_comb begin
      k_c = K_W'(STEP);
      if (count <= SHAMT_W'(STEP)) begin
         k_c = K_W'(count);
      end
   end

   srx_step u_step (
      .word    (work),
      .k       (k_c),
      .fill    (fill),
      .shifted (step_word)
   );

   assign ready_o = (state == SRX_IDLE) && !rst_i;
   assign valid_o = valid_q;
   assign s_o     = valid_q ? work : '0;

   // Control FSM and datapath registers; reset discards any in-flight request.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= SRX_IDLE;
         work    <= '0;
         count   <= '0;
         fill    <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         case (state)
            SRX_IDLE: begin
               if (start_i) begin
                  work  <= a_i;
                  count <= shift_i;
                  fill  <= arith_i & a_i[DATA_W-1];
                  state <= SRX_SHIFT;
               end
            end
            SRX_SHIFT: begin
               work  <= step_word;
               count <= count - SHAMT_W'(k_c);
               if (count <= SHAMT_W'(STEP)) begin
                  state   <= SRX_DONE;
                  valid_q <= 1'b1;
               end
            end
            SRX_DONE: begin
               if (ack_i) begin
                  state   <= SRX_IDLE;
                  valid_q <= 1'b0;
               end
            end
            default: begin
               state   <= SRX_IDLE;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

endmodule : srx_iter_32bit

// File: tb/tb_srx_iter_32bit.sv
// Directed self-checking bench for srx_iter_32bit.
module tb_srx_iter_32bit;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic        ready_o;
   logic [31:0] a_i;
   logic [4:0]  shift_i;
   logic        arith_i;
   logic [31:0] s_o;
   logic        valid_o;
   logic        ack_i;

   int n_checks = 0;
   int n_fail   = 0;

   srx_iter_32bit dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .start_i (start_i),
      .ready_o (ready_o),
      .a_i     (a_i),
      .shift_i (shift_i),
      .arith_i (arith_i),
      .s_o     (s_o),
      .valid_o (valid_o),
      .ack_i   (ack_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Issue one request, measure latency, check the result, then acknowledge.
   task automatic run_op(input string tag, input logic [31:0] a, input logic [4:0] sh,
                         input logic ar, input logic ack_early,
                         input logic [31:0] exp_s, input int exp_lat);
      int lat;
      check({tag, "_ready"}, 32'(ready_o), 32'd1);
      ack_i   = ack_early;
      start_i = 1'b1;
      a_i     = a;
      shift_i = sh;
      arith_i = ar;
      tick();
      start_i = 1'b0;
      a_i     = 32'hDEAD_BEEF;
      shift_i = 5'd17;
      arith_i = ~ar;
      check({tag, "_busy"}, 32'(ready_o), 32'd0);
      lat = 0;
      while (!valid_o && lat < 40) begin
         tick();
         lat++;
      end
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check({tag, "_s"}, s_o, exp_s);
      ack_i = 1'b1;
      tick();
      ack_i = 1'b0;
      check({tag, "_vdrop"}, 32'(valid_o), 32'd0);
      check({tag, "_rdy_after"}, 32'(ready_o), 32'd1);
      check({tag, "_s_zero"}, s_o, 32'h0);
   endtask

   initial begin
      int lat;
      rst_i   = 1'b1;
      start_i = 1'b0;
      a_i     = '0;
      shift_i = '0;
      arith_i = 1'b0;
      ack_i   = 1'b0;
      tick();
      tick();
      check("rst_ready", 32'(ready_o), 32'd0);
      check("rst_valid", 32'(valid_o), 32'd0);
      check("rst_s", s_o, 32'h0);
      rst_i = 1'b0;
      #1;
      check("post_rst_ready", 32'(ready_o), 32'd1);
      tick();

      // Basic function, latency and boundary shift amounts.
      run_op("t1_srl4",   32'h8000_0000, 5'd4,  1'b0, 1'b1, 32'h0800_0000, 1);
      run_op("t2_sra31",  32'h8000_0000, 5'd31, 1'b1, 1'b0, 32'hFFFF_FFFF, 8);
      run_op("t2_srl31",  32'h8000_0000, 5'd31, 1'b0, 1'b0, 32'h0000_0001, 8);
      run_op("t3_sra0",   32'h1234_5678, 5'd0,  1'b1, 1'b0, 32'h1234_5678, 1);
      run_op("t4_srl5",   32'hF000_000F, 5'd5,  1'b0, 1'b0, 32'h0780_0000, 2);
      run_op("t4_sra5",   32'hF000_000F, 5'd5,  1'b1, 1'b0, 32'hFF80_0000, 2);
      run_op("sra_pos",   32'h7000_0000, 5'd8,  1'b1, 1'b0, 32'h0070_0000, 2);
      run_op("sra4",      32'h8000_0000, 5'd4,  1'b1, 1'b1, 32'hF800_0000, 1);
      run_op("srl9",      32'hFFFF_FFFF, 5'd9,  1'b0, 1'b0, 32'h007F_FFFF, 3);

      // Backpressure: hold result while new requests are offered.
      start_i = 1'b1; a_i = 32'hF000_000F; shift_i = 5'd5; arith_i = 1'b1;
      tick();
      start_i = 1'b0;
      lat = 0;
      while (!valid_o && lat < 40) begin
         tick();
         lat++;
      end
      check("bp_lat", 32'(lat), 32'd2);
      for (int i = 0; i < 5; i++) begin
         start_i = 1'b1; a_i = 32'h0000_00FF; shift_i = 5'd4; arith_i = 1'b0;
         tick();
         check("bp_valid", 32'(valid_o), 32'd1);
         check("bp_s", s_o, 32'hFF80_0000);
         check("bp_ready", 32'(ready_o), 32'd0);
      end
      ack_i = 1'b1;
      tick();
      ack_i = 1'b0;
      check("bp_ack_ready", 32'(ready_o), 32'd1);
      check("bp_ack_valid", 32'(valid_o), 32'd0);
      start_i = 1'b0;
      run_op("bp_next", 32'h0000_00FF, 5'd4, 1'b0, 1'b0, 32'h0000_000F, 1);

      // Reset in the second SHIFT cycle discards the request.
      start_i = 1'b1; a_i = 32'hFFFF_0000; shift_i = 5'd20; arith_i = 1'b0;
      tick();
      start_i = 1'b0;
      tick();
      rst_i = 1'b1;
      #1;
      check("mid_rst_ready", 32'(ready_o), 32'd0);
      tick();
      rst_i = 1'b0;
      #1;
      check("mid_rst_ready_after", 32'(ready_o), 32'd1);
      check("mid_rst_valid", 32'(valid_o), 32'd0);
      check("mid_rst_s", s_o, 32'h0);
      lat = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (valid_o) lat++;
      end
      check("mid_rst_no_valid", 32'(lat), 32'd0);
      check("mid_rst_idle", 32'(ready_o), 32'd1);
      run_op("post_rst", 32'hFFFF_0000, 5'd20, 1'b1, 1'b0, 32'hFFFF_FFFF, 5);
      run_op("post_rst2", 32'h8765_4321, 5'd12, 1'b0, 1'b0, 32'h0008_7654, 3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_srx_iter_32bit
